// File: rtl/change_dispense_ctrl.sv
// Coin-return hopper sequencer: latches the change owed, then ejects coins greedily
// (50/10/5/1, limited by inventory) over a req/ack handshake with an ack timeout.
module change_dispense_ctrl #(
   parameter int unsigned AMT_W       = 8,
   parameter int unsigned CNT_W       = 6,
   parameter int unsigned INIT_CNT    = 10,
   parameter int unsigned ACK_TIMEOUT = 15
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic [AMT_W-1:0] i_amount,
   output logic             o_eject_req,
   output logic [AMT_W-1:0] o_eject_coin,
   input  logic             i_eject_ack,
   input  logic             i_refill,
   input  logic [1:0]       i_refill_sel,
   input  logic [CNT_W-1:0] i_refill_cnt,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_short,
   output logic [AMT_W-1:0] o_remain,
   output logic             o_fault
);

   localparam int unsigned TO_W = $clog2(ACK_TIMEOUT + 1);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_SELECT   = 3'd1;
   localparam logic [2:0] S_WAIT_ACK = 3'd2;
   localparam logic [2:0] S_DONE     = 3'd3;
   localparam logic [2:0] S_FAULT    = 3'd4;

   // Index 0 is the largest coin; the select loop gives it the highest priority.
   localparam logic [3:0][AMT_W-1:0] COIN_VAL =
      {AMT_W'(1), AMT_W'(5), AMT_W'(10), AMT_W'(50)};

   logic [2:0]             r_state;
   logic                   r_req;
   logic [AMT_W-1:0]       r_coin;
   logic [1:0]             r_idx;
   logic                   r_busy;
   logic                   r_done;
   logic                   r_short;
   logic [AMT_W-1:0]       r_remain;
   logic                   r_fault;
   logic [TO_W-1:0]        r_tcnt;
   logic [3:0][CNT_W-1:0]  r_inv;

   logic [2:0]             w_state_nxt;
   logic                   w_req_nxt;
   logic [AMT_W-1:0]       w_coin_nxt;
   logic [1:0]             w_idx_nxt;
   logic                   w_busy_nxt;
   logic                   w_done_nxt;
   logic                   w_short_nxt;
   logic [AMT_W-1:0]       w_remain_nxt;
   logic                   w_fault_nxt;
   logic [TO_W-1:0]        w_tcnt_nxt;
   logic [3:0][CNT_W-1:0]  w_inv_nxt;

   logic                   w_sel_found;
   logic [1:0]             w_sel_idx;

   // Greedy coin choice: largest denomination that fits the remainder and is in stock.
   always_comb begin
      w_sel_found = 1'b0;
      w_sel_idx   = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if ((COIN_VAL[2'(i)] <= r_remain) && (r_inv[2'(i)] != '0)) begin
            w_sel_found = 1'b1;
            w_sel_idx   = 2'(i);
         end
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      w_state_nxt  = r_state;
      w_req_nxt    = r_req;
      w_coin_nxt   = r_coin;
      w_idx_nxt    = r_idx;
      w_busy_nxt   = r_busy;
      w_done_nxt   = 1'b0;
      w_short_nxt  = r_short;
      w_remain_nxt = r_remain;
      w_fault_nxt  = r_fault;
      w_tcnt_nxt   = r_tcnt;
      w_inv_nxt    = r_inv;

      case (r_state)
         S_IDLE: begin
            w_busy_nxt = 1'b0;
            if (i_start) begin
               w_remain_nxt = i_amount;
               w_short_nxt  = 1'b0;
               w_busy_nxt   = 1'b1;
               w_state_nxt  = S_SELECT;
            end else if (i_refill) begin
               w_inv_nxt[i_refill_sel] = i_refill_cnt;
            end
         end

         S_SELECT: begin
            if (w_sel_found) begin
               w_req_nxt   = 1'b1;
               w_coin_nxt  = COIN_VAL[w_sel_idx];
               w_idx_nxt   = w_sel_idx;
               w_tcnt_nxt  = '0;
               w_state_nxt = S_WAIT_ACK;
            end else begin
               w_short_nxt = (r_remain != '0);
               w_done_nxt  = 1'b1;
               w_state_nxt = S_DONE;
            end
         end

         S_WAIT_ACK: begin
            if (i_eject_ack) begin
               w_remain_nxt = r_remain - r_coin;
               if (r_inv[r_idx] != '0) begin
                  w_inv_nxt[r_idx] = r_inv[r_idx] - CNT_W'(1);
               end
               w_req_nxt   = 1'b0;
               w_coin_nxt  = '0;
               w_state_nxt = S_SELECT;
            end else if (r_tcnt == TO_W'(ACK_TIMEOUT - 1)) begin
               w_req_nxt   = 1'b0;
               w_coin_nxt  = '0;
               w_fault_nxt = 1'b1;
               w_state_nxt = S_FAULT;
            end else begin
               w_tcnt_nxt = r_tcnt + TO_W'(1);
            end
         end

         S_DONE: begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
         end

         S_FAULT: begin
            w_state_nxt = S_FAULT;
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state  <= S_IDLE;
         r_req    <= 1'b0;
         r_coin   <= '0;
         r_idx    <= 2'd0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_short  <= 1'b0;
         r_remain <= '0;
         r_fault  <= 1'b0;
         r_tcnt   <= '0;
         r_inv    <= {4{CNT_W'(INIT_CNT)}};
      end else begin
         r_state  <= w_state_nxt;
         r_req    <= w_req_nxt;
         r_coin   <= w_coin_nxt;
         r_idx    <= w_idx_nxt;
         r_busy   <= w_busy_nxt;
         r_done   <= w_done_nxt;
         r_short  <= w_short_nxt;
         r_remain <= w_remain_nxt;
         r_fault  <= w_fault_nxt;
         r_tcnt   <= w_tcnt_nxt;
         r_inv    <= w_inv_nxt;
      end
   end

   assign o_eject_req  = r_req;
   assign o_eject_coin = r_coin;
   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_short      = r_short;
   assign o_remain     = r_remain;
   assign o_fault      = r_fault;

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Scoreboard bench for change_dispense_ctrl: a greedy inventory model queues the
// expected coins and remainders; a negedge monitor pops and compares them.
module tb_change_dispense_ctrl;

   logic       clk;
   logic       i_reset;
   logic       i_start;
   logic [7:0] i_amount;
   logic       o_eject_req;
   logic [7:0] o_eject_coin;
   logic       i_eject_ack;
   logic       i_refill;
   logic [1:0] i_refill_sel;
   logic [5:0] i_refill_cnt;
   logic       o_busy;
   logic       o_done;
   logic       o_short;
   logic [7:0] o_remain;
   logic       o_fault;

   change_dispense_ctrl dut (
      .i_clk        (clk),
      .i_reset      (i_reset),
      .i_start      (i_start),
      .i_amount     (i_amount),
      .o_eject_req  (o_eject_req),
      .o_eject_coin (o_eject_coin),
      .i_eject_ack  (i_eject_ack),
      .i_refill     (i_refill),
      .i_refill_sel (i_refill_sel),
      .i_refill_cnt (i_refill_cnt),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_short      (o_short),
      .o_remain     (o_remain),
      .o_fault      (o_fault)
   );

   int n_vec = 0;
   int n_bad = 0;
   int exp_coin_q[$];
   int exp_rem_q[$];
   int model_inv[4];
   int coin_v[4] = '{50, 10, 5, 1};
   int ack_mode = 0;   // 0: ack one cycle after req, 1: ack held high, 2: never ack
   bit mon_en = 0;
   bit prev_req = 0;
   int mon_e;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   // Hopper model driving eject_ack.
   initial begin
      int age;
      age = 0;
      i_eject_ack = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (o_eject_req === 1'b1) age++;
         else age = 0;
         case (ack_mode)
            0:       i_eject_ack = (age == 2);
            1:       i_eject_ack = 1'b1;
            default: i_eject_ack = 1'b0;
         endcase
      end
   end

   // Monitor: coin on each req rise, remainder after each acknowledged coin.
   always @(negedge clk) begin
      if (mon_en) begin
         if (o_eject_req && !prev_req) begin
            n_vec++;
            if (exp_coin_q.size() == 0) begin
               n_bad++;
               $display("FAIL coin_unexpected: got coin %0d, required no eject", o_eject_coin);
            end else begin
               mon_e = exp_coin_q.pop_front();
               if (o_eject_coin !== 8'(mon_e)) begin
                  n_bad++;
                  $display("FAIL coin_value: got %0d, required %0d", o_eject_coin, mon_e);
               end
            end
         end
         if (!o_eject_req) begin
            n_vec++;
            if (o_eject_coin !== 8'd0) begin
               n_bad++;
               $display("FAIL coin_idle: got %0d, required 0", o_eject_coin);
            end
         end
         if (prev_req && !o_eject_req && o_busy && !o_fault) begin
            n_vec++;
            if (exp_rem_q.size() == 0) begin
               n_bad++;
               $display("FAIL remain_unexpected: got %0d, required no step", o_remain);
            end else begin
               mon_e = exp_rem_q.pop_front();
               if (o_remain !== 8'(mon_e)) begin
                  n_bad++;
                  $display("FAIL remain_step: got %0d, required %0d", o_remain, mon_e);
               end
            end
         end
         prev_req = o_eject_req;
      end
   end

   task automatic model_push(input int amt, output int rem, output bit shrt);
      bit found;
      rem = amt;
      found = 1'b1;
      while (found) begin
         found = 1'b0;
         for (int i = 0; i < 4; i++) begin
            if (!found && coin_v[i] <= rem && model_inv[i] > 0) begin
               found = 1'b1;
               model_inv[i]--;
               rem -= coin_v[i];
               exp_coin_q.push_back(coin_v[i]);
               exp_rem_q.push_back(rem);
            end
         end
      end
      shrt = (rem != 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      i_reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      i_reset = 1'b0;
      for (int i = 0; i < 4; i++) model_inv[i] = 10;
      exp_coin_q.delete();
      exp_rem_q.delete();
      mon_en = 1'b1;
   endtask

   task automatic do_refill(input int sel, input int cnt);
      @(negedge clk);
      i_refill = 1'b1;
      i_refill_sel = 2'(sel);
      i_refill_cnt = 6'(cnt);
      @(negedge clk);
      i_refill = 1'b0;
      model_inv[sel] = cnt;
   endtask

   task automatic run_txn(input int amt, input int mode, input bit extra,
                          output int lat, output int busy_cnt);
      int er;
      bit es;
      bit seen;
      int cyc;
      model_push(amt, er, es);
      ack_mode = mode;
      @(negedge clk);
      i_start = 1'b1;
      i_amount = 8'(amt);
      seen = 1'b0;
      cyc = 0;
      busy_cnt = 0;
      while (!seen && cyc < 400) begin
         @(negedge clk);
         if (cyc == 0) i_start = 1'b0;
         if (extra && cyc == 2) begin
            i_start = 1'b1;
            i_amount = 8'd99;
         end
         if (extra && cyc == 3) i_start = 1'b0;
         cyc++;
         if (o_busy) busy_cnt++;
         if (o_done) seen = 1'b1;
      end
      lat = cyc;
      n_vec++;
      if (!seen) begin
         n_bad++;
         $display("FAIL done_timeout: no done within %0d cycles for amount %0d, required done", cyc, amt);
      end else begin
         n_vec++;
         if (o_short !== es) begin
            n_bad++;
            $display("FAIL short_flag: amount %0d got %0b, required %0b", amt, o_short, es);
         end
         n_vec++;
         if (o_remain !== 8'(er)) begin
            n_bad++;
            $display("FAIL remain_final: amount %0d got %0d, required %0d", amt, o_remain, er);
         end
      end
      n_vec++;
      if (exp_coin_q.size() != 0 || exp_rem_q.size() != 0) begin
         n_bad++;
         $display("FAIL coins_missing: %0d coins / %0d steps outstanding, required 0",
                  exp_coin_q.size(), exp_rem_q.size());
         exp_coin_q.delete();
         exp_rem_q.delete();
      end
      @(negedge clk);
      n_vec++;
      if (o_done !== 1'b0 || o_busy !== 1'b0) begin
         n_bad++;
         $display("FAIL done_after: done=%0b busy=%0b, required 0 0", o_done, o_busy);
      end
      ack_mode = 0;
   endtask

   task automatic test_reset();
      do_reset();
      n_vec++;
      if ({o_eject_req, o_eject_coin, o_busy, o_done, o_short, o_remain, o_fault} !== 20'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: req=%0b coin=%0d busy=%0b done=%0b short=%0b remain=%0d fault=%0b, required all 0",
                  o_eject_req, o_eject_coin, o_busy, o_done, o_short, o_remain, o_fault);
      end
   endtask

   task automatic test_full();
      int lat, bc;
      do_reset();
      run_txn(66, 0, 1'b0, lat, bc);
   endtask

   // Continues from test_full: 10 and 5 counters should now hold 9.
   task automatic test_drain();
      int lat, bc;
      do_refill(0, 2);
      run_txn(200, 0, 1'b0, lat, bc);
   endtask

   task automatic test_short();
      int lat, bc;
      do_reset();
      do_refill(3, 0);
      do_refill(2, 0);
      run_txn(13, 0, 1'b0, lat, bc);
   endtask

   task automatic test_zero();
      int lat, bc;
      run_txn(0, 0, 1'b0, lat, bc);
      n_vec++;
      if (lat != 2) begin
         n_bad++;
         $display("FAIL zero_latency: done after %0d cycles, required 2", lat);
      end
      n_vec++;
      if (bc != 2) begin
         n_bad++;
         $display("FAIL zero_busy: busy high %0d cycles, required 2", bc);
      end
   endtask

   task automatic test_timeout();
      int req_cyc;
      bit done_seen;
      do_reset();
      ack_mode = 2;
      exp_coin_q.push_back(10);
      @(negedge clk);
      i_start = 1'b1;
      i_amount = 8'd20;
      @(negedge clk);
      i_start = 1'b0;
      req_cyc = 0;
      done_seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (o_eject_req) req_cyc++;
         if (o_done) done_seen = 1'b1;
      end
      n_vec++;
      if (req_cyc != 15) begin
         n_bad++;
         $display("FAIL timeout_req_cycles: got %0d, required 15", req_cyc);
      end
      n_vec++;
      if (o_fault !== 1'b1 || o_busy !== 1'b1 || done_seen) begin
         n_bad++;
         $display("FAIL timeout_state: fault=%0b busy=%0b done_seen=%0b, required 1 1 0",
                  o_fault, o_busy, done_seen);
      end
      @(negedge clk);
      i_start = 1'b1;
      i_amount = 8'd5;
      i_refill = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      i_refill = 1'b0;
      repeat (5) @(negedge clk);
      n_vec++;
      if (o_fault !== 1'b1 || o_eject_req !== 1'b0 || o_done !== 1'b0) begin
         n_bad++;
         $display("FAIL fault_sticky: fault=%0b req=%0b done=%0b, required 1 0 0",
                  o_fault, o_eject_req, o_done);
      end
      ack_mode = 0;
      do_reset();
      n_vec++;
      if (o_fault !== 1'b0 || o_busy !== 1'b0) begin
         n_bad++;
         $display("FAIL fault_clear: fault=%0b busy=%0b, required 0 0", o_fault, o_busy);
      end
   endtask

   task automatic test_cont_ack();
      int lat, bc;
      do_reset();
      run_txn(30, 1, 1'b1, lat, bc);
      // With no 50s, the next payout exposes the 10 counter (model expects 7).
      do_refill(0, 0);
      run_txn(200, 0, 1'b0, lat, bc);
   endtask

   task automatic test_reset_mid();
      int lat, bc, w;
      do_reset();
      ack_mode = 2;
      exp_coin_q.push_back(50);
      @(negedge clk);
      i_start = 1'b1;
      i_amount = 8'd50;
      @(negedge clk);
      i_start = 1'b0;
      w = 0;
      while (o_eject_req !== 1'b1 && w < 10) begin
         @(negedge clk);
         w++;
      end
      n_vec++;
      if (o_eject_req !== 1'b1) begin
         n_bad++;
         $display("FAIL midreset_req: req=%0b, required 1", o_eject_req);
      end
      repeat (3) @(negedge clk);
      i_reset = 1'b1;
      @(negedge clk);
      n_vec++;
      if (o_eject_req !== 1'b0 || o_busy !== 1'b0 || o_remain !== 8'd0 || o_eject_coin !== 8'd0) begin
         n_bad++;
         $display("FAIL midreset_clear: req=%0b busy=%0b remain=%0d coin=%0d, required 0 0 0 0",
                  o_eject_req, o_busy, o_remain, o_eject_coin);
      end
      i_reset = 1'b0;
      ack_mode = 0;
      for (int i = 0; i < 4; i++) model_inv[i] = 10;
      exp_coin_q.delete();
      exp_rem_q.delete();
      run_txn(5, 0, 1'b0, lat, bc);
   endtask

   initial begin
      i_reset = 1'b1;
      i_start = 1'b0;
      i_amount = 8'd0;
      i_refill = 1'b0;
      i_refill_sel = 2'd0;
      i_refill_cnt = 6'd0;
      test_reset();
      test_full();
      test_drain();
      test_short();
      test_zero();
      test_timeout();
      test_cont_ack();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/change_dispense_ctrl.md
Name: change_dispense_ctrl

Overview:
Controller that sequences the coin-return hopper for the vending FSM. On a start pulse it latches the change amount owed. It then ejects coins one at a time over a req/ack handshake, choosing denominations greedily from 50/10/5/1 limited by on-board inventory. It reports done, any shortfall and handshake faults back to the vending FSM.

Parameters:
AMT_W, 8, width of amount, remaining amount and coin value buses
CNT_W, 6, width of each per-denomination inventory counter
INIT_CNT, 10, inventory loaded into all four counters on reset
ACK_TIMEOUT, 15, maximum cycles eject_req may stay high without eject_ack before fault

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin dispensing; honoured only in IDLE
amount  in  AMT_W  change owed; latched when start is accepted
eject_req  out  1  request to hopper to eject one coin of eject_coin
eject_coin  out  AMT_W  coin value being ejected (50, 10, 5 or 1); 0 when eject_req=0
eject_ack  in  1  hopper confirms ejection; sampled only while eject_req=1
refill  in  1  load inventory counter selected by refill_sel; honoured only in IDLE
refill_sel  in  2  0=50, 1=10, 2=5, 3=1
refill_cnt  in  CNT_W  value loaded into the selected counter
busy  out  1  high from the cycle after start is accepted until the DONE cycle (inclusive)
done  out  1  one-cycle pulse when dispensing ends
short  out  1  set at done if change could not be fully paid; held until next accepted start
remain  out  AMT_W  amount still owed; live during dispensing, held after done
fault  out  1  ack timeout; sticky until reset

Behaviour:
- Reset (synchronous, active-high): state=IDLE; eject_req=0, eject_coin=0, busy=0, done=0, short=0, remain=0, fault=0; all four inventory counters = INIT_CNT; timeout counter=0.
- States: IDLE, SELECT, WAIT_ACK, DONE, FAULT.
- IDLE: start=1 sets remain<=amount, short<=0, state<=SELECT, busy<=1. Refill is processed when start=0. If start and refill are high in the same cycle, start wins and refill is dropped.
- SELECT (one cycle): pick the largest coin in the order 50, 10, 5, 1 that satisfies coin<=remain and count>0.
  - Coin found: eject_req<=1, eject_coin<=coin, timeout counter<=0, state<=WAIT_ACK.
  - remain==0: state<=DONE, short<=0.
  - remain>0 and no eligible coin: state<=DONE, short<=1.
- WAIT_ACK: eject_req and eject_coin are held stable.
  - eject_ack=1: remain<=remain-eject_coin; that coin's counter decrements; eject_req<=0; eject_coin<=0; state<=SELECT.
  - Otherwise the timeout counter increments. When it reaches ACK_TIMEOUT with no ack: eject_req<=0, fault<=1, state<=FAULT.
- Handshake timing: an ack in the same cycle eject_req first rises counts. Minimum 2 cycles per coin, since eject_req drops for at least one cycle between coins. An ack held high continuously therefore yields exactly one decrement per coin.
- DONE: done=1 and busy=1 for this one cycle, then state<=IDLE.
- FAULT: absorbing state until reset. busy stays 1, done is never pulsed, start and refill are ignored.
- Timing example: start accepted at edge k, so SELECT after k and eject_req=1 after k+1. amount=0 gives done pulse after edge k+1, i.e. 2 cycles after start.
- start while busy is ignored, as is refill outside IDLE.
- remain never underflows, because only coins <= remain are selected.
- Counters never go below 0.
- Reset mid-operation returns everything to reset values in the next cycle, including eject_req=0 and inventory=INIT_CNT.

Test Plan:
- Full inventory, start with amount=66, ack 1 cycle after each req -> coins ejected in order 50,10,5,1; remain steps 66→16→6→1→0; done pulse with short=0; inventories 9,9,9,9.
- IDLE refill sel=3 cnt=0 and sel=2 cnt=0, then amount=13 -> one coin of 10 ejected, then done with short=1, remain=3.
- amount=0 -> no eject_req; done 2 cycles after start; short=0, busy high exactly 2 cycles.
- Start amount=20, never assert eject_ack -> eject_req high exactly 15 cycles then low, fault=1 sticky, no done; reset clears fault and restores counts to 10.
- eject_ack held high continuously with amount=30 -> exactly 3 coins of 10; 10-counter goes 10→7; second start pulse while busy ignored (remain unaffected).
- Reset asserted while in WAIT_ACK during amount=50 -> next cycle eject_req=0, busy=0, remain=0; all counts=10; subsequent start amount=5 completes normally.
